// File: rtl/ex_stage_md_pkg.sv
// ex_stage_md_pkg
//   Shared definitions for the execute stage and the ID decoder:
//   aluop code constants, divider FSM state encoding, word/address
//   constants and a small decode helper.
package ex_stage_md_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;
  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  // aluop codes (shared with ID decode)
  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_AND  = 8'h24;
  localparam logic [7:0] ALU_OR   = 8'h25;
  localparam logic [7:0] ALU_XOR  = 8'h26;
  localparam logic [7:0] ALU_NOR  = 8'h27;
  localparam logic [7:0] ALU_ADDU = 8'h21;
  localparam logic [7:0] ALU_SUBU = 8'h23;
  localparam logic [7:0] ALU_SLT  = 8'h2A;
  localparam logic [7:0] ALU_SLTU = 8'h2B;
  localparam logic [7:0] ALU_SLL  = 8'h7C;
  localparam logic [7:0] ALU_SRL  = 8'h02;
  localparam logic [7:0] ALU_SRA  = 8'h03;
  localparam logic [7:0] ALU_MFHI = 8'h10;
  localparam logic [7:0] ALU_MTHI = 8'h11;
  localparam logic [7:0] ALU_MFLO = 8'h12;
  localparam logic [7:0] ALU_MTLO = 8'h13;
  localparam logic [7:0] ALU_DIV  = 8'h1A;
  localparam logic [7:0] ALU_DIVU = 8'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/ex_stage_md_if.sv
// ex_stage_md_if
//   Bundles the ID/EX inputs and EX/MEM outputs of the execute stage.
//   slave  : the execute stage (consumes ID/EX, drives EX/MEM + stall)
//   master : the surrounding pipeline (drives ID/EX + flush)
//   Signals: flush, ex_aluop, ex_rs_data, ex_rt_data, ex_w_reg_addr, ex_wd,
//            ex_w_data_o, ex_w_reg_addr_o, ex_wd_o, stall_req, div_busy,
//            and with EX_FWD_EN: ex_fwd_wd, ex_fwd_addr, ex_fwd_data.
interface ex_stage_md_if;
  import ex_stage_md_pkg::*;

  logic                  flush;
  logic [7:0]            ex_aluop;
  logic [WORD_W-1:0]     ex_rs_data;
  logic [WORD_W-1:0]     ex_rt_data;
  logic [REG_ADDR_W-1:0] ex_w_reg_addr;
  logic                  ex_wd;

  logic [WORD_W-1:0]     ex_w_data_o;
  logic [REG_ADDR_W-1:0] ex_w_reg_addr_o;
  logic                  ex_wd_o;
  logic                  stall_req;
  logic                  div_busy;

`ifdef EX_FWD_EN
  logic                  ex_fwd_wd;
  logic [REG_ADDR_W-1:0] ex_fwd_addr;
  logic [WORD_W-1:0]     ex_fwd_data;

  modport slave (
    input  flush, ex_aluop, ex_rs_data, ex_rt_data, ex_w_reg_addr, ex_wd,
    output ex_w_data_o, ex_w_reg_addr_o, ex_wd_o, stall_req, div_busy,
    output ex_fwd_wd, ex_fwd_addr, ex_fwd_data
  );
  modport master (
    output flush, ex_aluop, ex_rs_data, ex_rt_data, ex_w_reg_addr, ex_wd,
    input  ex_w_data_o, ex_w_reg_addr_o, ex_wd_o, stall_req, div_busy,
    input  ex_fwd_wd, ex_fwd_addr, ex_fwd_data
  );
`else
  modport slave (
    input  flush, ex_aluop, ex_rs_data, ex_rt_data, ex_w_reg_addr, ex_wd,
    output ex_w_data_o, ex_w_reg_addr_o, ex_wd_o, stall_req, div_busy
  );
  modport master (
    output flush, ex_aluop, ex_rs_data, ex_rt_data, ex_w_reg_addr, ex_wd,
    input  ex_w_data_o, ex_w_reg_addr_o, ex_wd_o, stall_req, div_busy
  );
`endif

endinterface

// File: rtl/ex_stage_md_div_iter.sv
// div_iter
//   Iterative restoring divider, one quotient bit per cycle.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     start          begin a divide (sampled only in IDLE)
//     signed_op      1 = DIV (signed), 0 = DIVU
//     dividend       rs operand
//     divisor        rt operand
//     cancel         abort; FSM returns to IDLE next edge
//     busy           FSM not IDLE
//     done           FSM in DONE; quotient/remainder valid this cycle
//     quotient       sign-corrected quotient
//     remainder      sign-corrected remainder
//   Divide-by-zero skips CALC and reports quotient all-ones, remainder = dividend.
module div_iter
  import ex_stage_md_pkg::*;
#(
  parameter int DW   = 32,
  parameter int ITER = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          signed_op,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  input  logic          cancel,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    quo_q;   // shifts dividend out, quotient bits in
  logic [DW-1:0]    rem_q;
  logic [DW-1:0]    dsr_q;
  logic             neg_q_q; // negate quotient at the end
  logic             neg_r_q; // negate remainder at the end

  logic             div_by_zero;
  logic [DW:0]      partial;
  logic             fits;
  logic [DW-1:0]    step_rem;

  assign div_by_zero = (divisor == '0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (start) state_d = div_by_zero ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt_q == LAST_STEP) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (cancel) state_d = DIV_IDLE;
  end

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    partial  = {rem_q, quo_q[DW-1]};
    fits     = (partial >= {1'b0, dsr_q});
    step_rem = fits ? DW'(partial - {1'b0, dsr_q}) : partial[DW-1:0];
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (state_q == DIV_IDLE && start && !cancel) begin
      cnt_q <= '0;
      if (div_by_zero) begin
        // Preload the fixed divide-by-zero answer; no fixup applied.
        quo_q   <= '1;
        rem_q   <= dividend;
        dsr_q   <= '0;
        neg_q_q <= 1'b0;
        neg_r_q <= 1'b0;
      end else begin
        quo_q   <= (signed_op && dividend[DW-1]) ? -dividend : dividend;
        dsr_q   <= (signed_op && divisor[DW-1])  ? -divisor  : divisor;
        rem_q   <= '0;
        neg_q_q <= signed_op && (dividend[DW-1] ^ divisor[DW-1]);
        neg_r_q <= signed_op && dividend[DW-1];
      end
    end else if (state_q == DIV_CALC && !cancel) begin
      cnt_q <= cnt_q + 1'b1;
      quo_q <= {quo_q[DW-2:0], fits};
      rem_q <= step_rem;
    end
  end

  assign busy      = (state_q != DIV_IDLE);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = neg_q_q ? -quo_q : quo_q;
  assign remainder = neg_r_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md
//   Execute stage: single-cycle ALU/shift ops, HI/LO registers, and an
//   iterative divider that stalls the front of the pipeline while it runs.
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset
//     bus   ex_stage_md_if.slave: flush, ID/EX inputs, EX/MEM outputs,
//           stall_req, div_busy
//   Optional macro EX_FWD_EN: adds ex_fwd_wd/ex_fwd_addr/ex_fwd_data for
//   the ID bypass mux, zeroed while stalled or flushed.
module ex_stage_md
  import ex_stage_md_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DIV_ITER = 32
) (
  input logic          clk,
  input logic          rst,
  ex_stage_md_if.slave bus
);

  logic [DW-1:0] hi_q, lo_q;
  logic [DW-1:0] alu_data;
  logic          alu_wd;
  logic [4:0]    shamt;

  logic          is_div;
  logic          div_start;
  logic          div_busy;
  logic          div_done;
  logic [DW-1:0] div_quo, div_rem;
  logic          stall;

  assign shamt  = bus.ex_rt_data[4:0];
  assign is_div = is_div_op(bus.ex_aluop);

  // A divide starts only from IDLE; flush and reset both suppress it.
  assign div_start = is_div && !div_busy && !bus.flush && !rst;

  // Stall covers IDLE and CALC; DONE releases the pipeline so the DIV
  // leaves ID/EX on the same edge that commits HI/LO.
  assign stall = is_div && !div_done && !bus.flush && !rst;

  div_iter #(
    .DW   (DW),
    .ITER (DIV_ITER)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (bus.ex_aluop == ALU_DIV),
    .dividend  (bus.ex_rs_data),
    .divisor   (bus.ex_rt_data),
    .cancel    (bus.flush),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    alu_data = ZERO_WORD;
    alu_wd   = bus.ex_wd;
    unique case (bus.ex_aluop)
      ALU_AND:  alu_data = bus.ex_rs_data & bus.ex_rt_data;
      ALU_OR:   alu_data = bus.ex_rs_data | bus.ex_rt_data;
      ALU_XOR:  alu_data = bus.ex_rs_data ^ bus.ex_rt_data;
      ALU_NOR:  alu_data = ~(bus.ex_rs_data | bus.ex_rt_data);
      ALU_ADDU: alu_data = bus.ex_rs_data + bus.ex_rt_data;
      ALU_SUBU: alu_data = bus.ex_rs_data - bus.ex_rt_data;
      ALU_SLT:  alu_data = DW'($signed(bus.ex_rs_data) < $signed(bus.ex_rt_data));
      ALU_SLTU: alu_data = DW'(bus.ex_rs_data < bus.ex_rt_data);
      ALU_SLL:  alu_data = bus.ex_rs_data << shamt;
      ALU_SRL:  alu_data = bus.ex_rs_data >> shamt;
      ALU_SRA:  alu_data = $unsigned($signed(bus.ex_rs_data) >>> shamt);
      ALU_MFHI: alu_data = hi_q;
      ALU_MFLO: alu_data = lo_q;
      // MTHI/MTLO/DIV/DIVU/NOP and unknown codes write nothing to the GPR file.
      default:  alu_wd = 1'b0;
    endcase
  end

  // HI/LO: a completing divide wins; moves only commit when the stage advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_done && !bus.flush) begin
      hi_q <= div_rem;
      lo_q <= div_quo;
    end else if (!stall && !bus.flush) begin
      if (bus.ex_aluop == ALU_MTHI) hi_q <= bus.ex_rs_data;
      if (bus.ex_aluop == ALU_MTLO) lo_q <= bus.ex_rs_data;
    end
  end

  assign bus.ex_w_data_o     = rst ? ZERO_WORD : alu_data;
  assign bus.ex_w_reg_addr_o = rst ? '0 : bus.ex_w_reg_addr;
  assign bus.ex_wd_o         = rst ? 1'b0 : alu_wd;
  assign bus.stall_req       = stall;
  assign bus.div_busy        = div_busy;

`ifdef EX_FWD_EN
  logic fwd_block;
  assign fwd_block       = stall || bus.flush;
  assign bus.ex_fwd_wd   = fwd_block ? 1'b0 : bus.ex_wd_o;
  assign bus.ex_fwd_addr = fwd_block ? '0 : bus.ex_w_reg_addr_o;
  assign bus.ex_fwd_data = fwd_block ? ZERO_WORD : bus.ex_w_data_o;
`endif

endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md
//   Directed + randomized bench for ex_stage_md with a behavioural
//   reference model (plain arithmetic for ALU ops and division, model
//   HI/LO variables). Optional EX_FWD_EN adds forwarding-port checks.
module tb_ex_stage_md;
  import ex_stage_md_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_md_if bus ();

  ex_stage_md dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  localparam logic [7:0] SC_OPS [12] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_ADDU, ALU_SUBU,
                                          ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_NOP};
  localparam logic [7:0] KNOWN [18] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_ADDU, ALU_SUBU,
                                        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_NOP,
                                        ALU_MFHI, ALU_MTHI, ALU_MFLO, ALU_MTLO, ALU_DIV, ALU_DIVU};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] addr, input logic wd);
    bus.ex_aluop      = op;
    bus.ex_rs_data    = a;
    bus.ex_rt_data    = b;
    bus.ex_w_reg_addr = addr;
    bus.ex_wd         = wd;
  endtask

  // Reference: value an ALU op should produce, from the instruction semantics.
  function automatic logic [31:0] alu_ref(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb, sh;
    sa = a; sb = b; sh = b % 32;
    case (op)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_ADDU: return a + b;
      ALU_SUBU: return a - b;
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return 32'(sa >>> sh);
      default:  return 32'd0;
    endcase
  endfunction

  function automatic void div_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
    int sa, sb;
    sa = a; sb = b;
    if (b == 0) begin
      lo = 32'hFFFF_FFFF; hi = a;
    end else if (op == ALU_DIVU) begin
      lo = a / b; hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000; hi = 32'h0;
    end else begin
      lo = 32'(sa / sb); hi = 32'(sa % sb);
    end
  endfunction

  task automatic read_hilo(input string tag);
    set_in(ALU_MFHI, $urandom, $urandom, 5'd3, 1'b1);
    #1;
    check({tag, "_mfhi"}, bus.ex_w_data_o, m_hi);
    check({tag, "_mfhi_wd"}, 32'(bus.ex_wd_o), 32'd1);
    tick();
    set_in(ALU_MFLO, $urandom, $urandom, 5'd4, 1'b1);
    #1;
    check({tag, "_mflo"}, bus.ex_w_data_o, m_lo);
    tick();
    set_in(ALU_NOP, 0, 0, 0, 1'b0);
  endtask

  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
    int n;
    logic [31:0] eh, el;
    div_ref(op, a, b, eh, el);
    set_in(op, a, b, 5'd7, 1'b1);
    #1;
    check({tag, "_data"}, bus.ex_w_data_o, 32'd0);
    check({tag, "_wd"}, 32'(bus.ex_wd_o), 32'd0);
`ifdef EX_FWD_EN
    check({tag, "_fwd_wd"}, 32'(bus.ex_fwd_wd), 32'd0);
`endif
    n = 0;
    while (bus.stall_req === 1'b1 && n < 40) begin
      n++;
      tick();
`ifdef EX_FWD_EN
      if (bus.stall_req === 1'b1) check({tag, "_fwd_stall"}, 32'(bus.ex_fwd_wd), 32'd0);
`endif
    end
    check({tag, "_stall_cycles"}, n, (b == 0) ? 32'd1 : 32'd33);
    check({tag, "_busy_done"}, 32'(bus.div_busy), 32'd1);
    tick();
    m_hi = eh;
    m_lo = el;
    set_in(ALU_NOP, 0, 0, 0, 1'b0);
    #1;
    check({tag, "_busy_idle"}, 32'(bus.div_busy), 32'd0);
    read_hilo(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [7:0]  op;
    logic        wd;
    logic [4:0]  addr;

    // Reset: outputs forced low even with live inputs
    rst = 1'b1;
    bus.flush = 1'b0;
    set_in(ALU_ADDU, 32'h5, 32'h6, 5'd9, 1'b1);
    #2;
    check("rst_data", bus.ex_w_data_o, 32'd0);
    check("rst_addr", 32'(bus.ex_w_reg_addr_o), 32'd0);
    check("rst_wd", 32'(bus.ex_wd_o), 32'd0);
    set_in(ALU_DIV, 32'd7, 32'd3, 5'd3, 1'b1);
    #1;
    check("rst_stall", 32'(bus.stall_req), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    set_in(ALU_NOP, 0, 0, 0, 1'b0);
    #1;
    check("rst_busy", 32'(bus.div_busy), 32'd0);
    m_hi = 0;
    m_lo = 0;
    read_hilo("rst_hilo");

    // ADDU wrap
    set_in(ALU_ADDU, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    #1;
    check("addu_wrap_data", bus.ex_w_data_o, 32'd0);
    check("addu_wrap_wd", 32'(bus.ex_wd_o), 32'd1);
    check("addu_wrap_addr", 32'(bus.ex_w_reg_addr_o), 32'd5);
    check("addu_wrap_stall", 32'(bus.stall_req), 32'd0);
    tick();

    // Random single-cycle ops
    for (int i = 0; i < 40; i++) begin
      op   = SC_OPS[$urandom_range(0, 11)];
      a    = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      b    = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      wd   = 1'($urandom);
      addr = 5'($urandom);
      set_in(op, a, b, addr, wd);
      #1;
      check($sformatf("alu_%0h_data", op), bus.ex_w_data_o, alu_ref(op, a, b));
      check($sformatf("alu_%0h_wd", op), 32'(bus.ex_wd_o), (op == ALU_NOP) ? 32'd0 : 32'(wd));
      check($sformatf("alu_%0h_addr", op), 32'(bus.ex_w_reg_addr_o), 32'(addr));
      check("alu_stall", 32'(bus.stall_req), 32'd0);
`ifdef EX_FWD_EN
      check("fwd_data", bus.ex_fwd_data, alu_ref(op, a, b));
      check("fwd_addr", 32'(bus.ex_fwd_addr), 32'(addr));
`endif
      tick();
    end

    // Unknown codes behave as NOP
    for (int i = 0; i < 6; i++) begin
      logic known;
      do begin
        op = 8'($urandom_range(0, 255));
        known = 1'b0;
        for (int k = 0; k < 18; k++) if (KNOWN[k] == op) known = 1'b1;
      end while (known);
      set_in(op, $urandom, $urandom, 5'd11, 1'b1);
      #1;
      check($sformatf("unk_%0h_data", op), bus.ex_w_data_o, 32'd0);
      check($sformatf("unk_%0h_wd", op), 32'(bus.ex_wd_o), 32'd0);
      tick();
    end

    // MTHI / MTLO
    a = $urandom;
    set_in(ALU_MTHI, a, $urandom, 5'd2, 1'b1);
    #1;
    check("mthi_wd", 32'(bus.ex_wd_o), 32'd0);
    tick();
    m_hi = a;
    a = $urandom;
    set_in(ALU_MTLO, a, $urandom, 5'd2, 1'b1);
    tick();
    m_lo = a;
    read_hilo("mt");

    // Directed divides, then random ones
    run_div(ALU_DIVU, 32'd100, 32'd7, "divu_100_7");
    run_div(ALU_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_div(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_div(ALU_DIV, 32'h1234, 32'd0, "div_zero");
    run_div(ALU_DIVU, 32'hDEAD_BEEF, 32'd0, "divu_zero");
    run_div(ALU_DIV, 32'd37, 32'hFFFF_FFFB, "div_37_m5");
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i == 2) ? 32'(1 << $urandom_range(0, 31)) : ($urandom >> $urandom_range(0, 28));
      if (b == 0) b = 32'd3;
      run_div((i % 2 == 0) ? ALU_DIV : ALU_DIVU, a, b, $sformatf("div_rand%0d", i));
    end

    // Flush mid-divide leaves HI/LO untouched
    set_in(ALU_MTHI, 32'hAA, 0, 0, 1'b0);
    tick();
    set_in(ALU_MTLO, 32'h55, 0, 0, 1'b0);
    tick();
    m_hi = 32'hAA;
    m_lo = 32'h55;
    set_in(ALU_DIVU, 32'h1234_5678, 32'h13, 5'd6, 1'b1);
    #1;
    check("flush_stall_start", 32'(bus.stall_req), 32'd1);
    tick();
    repeat (10) tick();
    check("flush_busy_calc", 32'(bus.div_busy), 32'd1);
    bus.flush = 1'b1;
    #1;
    check("flush_stall_drop", 32'(bus.stall_req), 32'd0);
`ifdef EX_FWD_EN
    check("flush_fwd_wd", 32'(bus.ex_fwd_wd), 32'd0);
`endif
    tick();
    bus.flush = 1'b0;
    set_in(ALU_NOP, 0, 0, 0, 1'b0);
    #1;
    check("flush_busy_idle", 32'(bus.div_busy), 32'd0);
    repeat (40) tick();
    read_hilo("flush");

    // Reset mid-divide
    set_in(ALU_DIV, 32'h7FFF_0000, 32'd3, 5'd8, 1'b1);
    tick();
    repeat (20) tick();
    check("rstdiv_busy_calc", 32'(bus.div_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstdiv_stall", 32'(bus.stall_req), 32'd0);
    check("rstdiv_data", bus.ex_w_data_o, 32'd0);
    check("rstdiv_addr", 32'(bus.ex_w_reg_addr_o), 32'd0);
    check("rstdiv_wd", 32'(bus.ex_wd_o), 32'd0);
    tick();
    check("rstdiv_busy", 32'(bus.div_busy), 32'd0);
    rst = 1'b0;
    set_in(ALU_NOP, 0, 0, 0, 1'b0);
    m_hi = 0;
    m_lo = 0;
    read_hilo("rstdiv");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
